// File: rtl/dram_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM: mode-driven grants,
// registered RAM issue, and a read-tag pipeline that routes mem_q back to its issuer.
module dram_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic              clock_i,
    input  logic              rst_n_i,
    input  logic [1:0]        status_i,
    input  logic              p_req_i,
    input  logic              p_we_i,
    input  logic [ADDR_W-1:0] p_addr_i,
    input  logic [DATA_W-1:0] p_wdata_i,
    output logic              p_gnt_o,
    output logic              p_rvalid_o,
    output logic [DATA_W-1:0] p_rdata_o,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wren_o,
    input  logic [DATA_W-1:0] mem_q_i
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD     = 2'b01,
        ST_PROCESS  = 2'b10,
        ST_TRANSMIT = 2'b11
    } status_e;

    typedef struct packed {
        logic rd;
        logic own_c;
    } tag_t;

    logic              p_gnt, c_gnt, p_xfer, c_xfer;
    logic [CNT_W-1:0]  starve_q, starve_d;
    tag_t [RD_LAT:0]   tag_q;
    tag_t              tag_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q, p_rdata_q, c_rdata_q;
    logic              mem_wren_q, p_rvalid_q, c_rvalid_q;

    // Grants are gated by reset so they read 0 while reset is held.
    always_comb begin
        p_gnt = 1'b0;
        c_gnt = 1'b0;
        if (rst_n_i) begin
            case (status_e'(status_i))
                ST_LOAD, ST_TRANSMIT: c_gnt = c_req_i;
                ST_PROCESS: begin
                    if (c_req_i && starve_q == LIM) begin
                        c_gnt = 1'b1;
                    end else begin
                        p_gnt = p_req_i;
                        c_gnt = c_req_i & ~p_req_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_xfer = p_req_i & p_gnt;
    assign c_xfer = c_req_i & c_gnt;

    always_comb begin
        starve_d = starve_q;
        if (status_e'(status_i) != ST_PROCESS || !c_req_i || c_xfer)
            starve_d = '0;
        else if (p_xfer && starve_q != LIM)
            starve_d = starve_q + 1'b1;
    end

    always_comb begin
        tag_d.rd    = (p_xfer & ~p_we_i) | (c_xfer & ~c_we_i);
        tag_d.own_c = c_xfer;
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q   <= '0;
            tag_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            p_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            c_rdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            tag_q    <= {tag_q[RD_LAT-1:0], tag_d};

            mem_wren_q <= 1'b0;
            if (p_xfer) begin
                mem_addr_q <= p_addr_i;
                mem_data_q <= p_wdata_i;
                mem_wren_q <= p_we_i;
            end else if (c_xfer) begin
                mem_addr_q <= c_addr_i;
                mem_data_q <= c_wdata_i;
                mem_wren_q <= c_we_i;
            end

            // Last tag stage lines up with mem_q for that transfer.
            p_rvalid_q <= tag_q[RD_LAT].rd & ~tag_q[RD_LAT].own_c;
            c_rvalid_q <= tag_q[RD_LAT].rd &  tag_q[RD_LAT].own_c;
            if (tag_q[RD_LAT].rd && !tag_q[RD_LAT].own_c) p_rdata_q <= mem_q_i;
            if (tag_q[RD_LAT].rd &&  tag_q[RD_LAT].own_c) c_rdata_q <= mem_q_i;
        end
    end

    assign p_gnt_o    = p_gnt;
    assign c_gnt_o    = c_gnt;
    assign p_rvalid_o = p_rvalid_q;
    assign c_rvalid_o = c_rvalid_q;
    assign p_rdata_o  = p_rdata_q;
    assign c_rdata_o  = c_rdata_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_wren_o = mem_wren_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a write-first 1-cycle RAM model.
module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  status;
    logic        p_req, p_we, c_req, c_we;
    logic [15:0] p_addr, c_addr;
    logic [7:0]  p_wdata, c_wdata;
    logic        p_gnt, p_rvalid, c_gnt, c_rvalid, mem_wren;
    logic [7:0]  p_rdata, c_rdata, mem_data, mem_q;
    logic [15:0] mem_addr;

    logic [7:0]  ram [0:65535];
    int          n_tot = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dram_port_arbiter dut (
        .clock_i(clk), .rst_n_i(rst_n), .status_i(status),
        .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
        .p_gnt_o(p_gnt), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_wren_o(mem_wren),
        .mem_q_i(mem_q)
    );

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= mem_wren ? mem_data : ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_p(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
        p_req = req; p_we = we; p_addr = a; p_wdata = d;
    endtask

    task automatic drv_c(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
        c_req = req; c_we = we; c_addr = a; c_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0; status = 2'b10;
        drv_p(1'b1, 1'b0, 16'h0, 8'h0);
        drv_c(1'b1, 1'b0, 16'h0, 8'h0);
        #2;
        chk("rst_gnt", {p_gnt, c_gnt}, 2'b00);
        chk("rst_outs", {p_rvalid, c_rvalid, mem_wren, p_rdata, c_rdata, mem_data, mem_addr}, '0);
        tick; tick;
        status = 2'b00;
        drv_p(1'b0, 1'b0, 16'h0, 8'h0);
        drv_c(1'b0, 1'b0, 16'h0, 8'h0);
        #2 rst_n = 1'b1;
        tick;

        // LOAD: C writes while P also requests.
        status = 2'b01;
        drv_c(1'b1, 1'b1, 16'h0005, 8'hA3);
        drv_p(1'b1, 1'b0, 16'h0005, 8'h00);
        #1;
        chk("load_gnt", {p_gnt, c_gnt}, 2'b01);
        tick;
        chk("load_issue", {mem_wren, mem_addr, mem_data}, {1'b1, 16'h0005, 8'hA3});

        // PROCESS: P reads 0x0005.
        status = 2'b10;
        drv_c(1'b0, 1'b0, 16'h0, 8'h0);
        drv_p(1'b1, 1'b0, 16'h0005, 8'h00);
        #1;
        chk("proc_gnt", {p_gnt, c_gnt}, 2'b10);
        tick;
        drv_p(1'b0, 1'b0, 16'h0, 8'h0);
        chk("proc_issue", {mem_wren, mem_addr}, {1'b0, 16'h0005});
        chk("proc_rv1", {p_rvalid, c_rvalid}, 2'b00);
        tick;
        chk("proc_rv2", {p_rvalid, c_rvalid}, 2'b00);
        tick;
        chk("proc_rd", {p_rvalid, c_rvalid, p_rdata}, {2'b10, 8'hA3});
        tick;
        chk("proc_pulse_end", {p_rvalid, c_rvalid}, 2'b00);

        // Back-to-back write then read of the same address.
        drv_p(1'b1, 1'b1, 16'h0010, 8'h5C);
        tick;
        drv_p(1'b1, 1'b0, 16'h0010, 8'h00);
        tick;
        drv_p(1'b0, 1'b0, 16'h0, 8'h0);
        chk("b2b_rv1", p_rvalid, 1'b0);
        tick;
        chk("b2b_rv2", p_rvalid, 1'b0);
        tick;
        chk("b2b_rd", {p_rvalid, p_rdata}, {1'b1, 8'h5C});
        tick;
        chk("b2b_single", p_rvalid, 1'b0);

        // Starvation: both requesting continuously in PROCESS.
        drv_p(1'b1, 1'b1, 16'h0020, 8'h11);
        drv_c(1'b1, 1'b1, 16'h0030, 8'h22);
        for (int k = 0; k < 20; k++) begin
            #1;
            chk($sformatf("starve_%0d", k), {p_gnt, c_gnt},
                (k == 8 || k == 17) ? 2'b01 : 2'b10);
            tick;
        end

        // IDLE: nothing granted, no write issued.
        status = 2'b00;
        #1;
        chk("idle_gnt", {p_gnt, c_gnt}, 2'b00);
        tick;
        chk("idle_wren", mem_wren, 1'b0);

        // P read in flight, then switch to TRANSMIT.
        status = 2'b10;
        drv_c(1'b0, 1'b0, 16'h0, 8'h0);
        drv_p(1'b1, 1'b0, 16'h0010, 8'h00);
        tick;
        status = 2'b11;
        drv_c(1'b1, 1'b0, 16'h0005, 8'h00);
        #1;
        chk("tx_gnt", {p_gnt, c_gnt}, 2'b01);
        tick;
        drv_c(1'b0, 1'b0, 16'h0, 8'h0);
        drv_p(1'b0, 1'b0, 16'h0, 8'h0);
        tick;
        chk("tx_p_rd", {p_rvalid, c_rvalid, p_rdata}, {2'b10, 8'h5C});
        tick;
        chk("tx_c_rd", {p_rvalid, c_rvalid, c_rdata, p_rdata}, {2'b01, 8'hA3, 8'h5C});

        // Reset with a P read pending.
        status = 2'b10;
        drv_p(1'b1, 1'b0, 16'h0005, 8'h00);
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", {p_gnt, c_gnt}, 2'b00);
        chk("mid_rst_outs", {p_rvalid, c_rvalid, mem_wren, p_rdata, c_rdata, mem_data, mem_addr}, '0);
        drv_p(1'b0, 1'b0, 16'h0, 8'h0);
        tick;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("post_rst_rv_%0d", k), {p_rvalid, c_rvalid}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM (8-bit data, 16-bit address, synchronous read) between two requesters: the processor datapath (P) and the host communication loader/transmitter (C).
- Grants follow the global 2-bit status from the state controller.
- One transaction is issued per cycle. Each read is tagged in a pipeline so its data returns only to the requester that issued it.
- Sits between processor/comm logic and the data memory macro.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, clock edges from mem_addr valid to mem_q valid (RAM read latency, >=1)
- STARVE_LIM, 8, consecutive contested P wins in PROCESS before C is forced a grant (>=1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- status  in  2  00 IDLE, 01 LOAD, 10 PROCESS, 11 TRANSMIT
- p_req  in  1  processor request valid
- p_we  in  1  1=write, 0=read
- p_addr  in  ADDR_W  processor address
- p_wdata  in  DATA_W  processor write data
- p_gnt  out  1  combinational; transfer occurs when p_req&p_gnt at clock edge
- p_rvalid  out  1  one-cycle pulse, p_rdata valid
- p_rdata  out  DATA_W  read data for P
- c_req, c_we, c_addr, c_wdata, c_gnt, c_rvalid, c_rdata  same as P set, for comm requester
- mem_addr  out  ADDR_W  registered RAM address
- mem_data  out  DATA_W  registered RAM write data
- mem_wren  out  1  registered RAM write enable
- mem_q  in  DATA_W  RAM read data

Behaviour:
- Reset (rst_n=0, async): the following clear to 0 immediately and stay 0 while reset is held:
  - all gnt, rvalid, rdata, mem_addr, mem_data, mem_wren
  - read-tag pipeline
  - starvation counter
- Grant by mode (gnt is combinational from status, req and the starvation counter):
  - IDLE: p_gnt=c_gnt=0.
  - LOAD, TRANSMIT: c_gnt=c_req; p_gnt=0.
  - PROCESS: P has priority, so p_gnt=p_req and c_gnt=c_req&~p_req.
  - Exception in PROCESS: when starve_cnt==STARVE_LIM and c_req=1, then c_gnt=1 and p_gnt=0.
- At most one gnt is high in any cycle.
- Starvation counter:
  - Increments at each edge where P transfers while c_req=1.
  - Clears on any C transfer, on any cycle with c_req=0, and whenever status!=PROCESS.
  - Saturates at STARVE_LIM.
- Issue: at a transfer edge, mem_addr/mem_data/mem_wren are loaded from the winner's addr/wdata/we.
  - With no transfer, mem_wren<=0 and mem_addr/mem_data hold.
  - Requesters may present a new transaction in the cycle following a transfer. Back-to-back transfers are allowed every cycle.
- Read return:
  - Each transfer pushes tag {read, owner} into a shift pipeline of depth RD_LAT+1. Writes push read=0.
  - When the tag reaches the end of the pipeline, mem_q is registered into the owner's rdata and the owner's rvalid is pulsed for 1 cycle.
  - rvalid appears exactly RD_LAT+1 cycles after the handshake cycle (2 at default).
  - The non-owner's rdata holds its previous value; its rvalid stays 0.
- In-flight reads always complete, even if status changes mid-pipeline.
- A status change takes effect on gnt in the same cycle.
- Write then read to the same address on consecutive transfers returns the new data; the RAM is write-first and the ordering is preserved.
- Reset mid-read drops all pending rvalids. No rvalid pulse is produced after reset is released for any pre-reset transfer.
- rvalid to both requesters can never occur in the same cycle.

Test Plan:
- Reset: drive rst_n=0 mid-traffic, including a pending P read -> all outputs 0 immediately; after release, no rvalid pulse for the pending read.
- LOAD writes: status=01, C writes addr 0x0005 data 0xA3 with p_req=1 held -> p_gnt stays 0; mem_wren=1, mem_addr=0x0005, mem_data=0xA3 in cycle after handshake.
- PROCESS read: status=10, P reads 0x0005 -> p_rvalid pulse 2 cycles after handshake with p_rdata=0xA3; c_rvalid stays 0.
- Back-to-back mixed: P write 0x0010=0x5C then P read 0x0010 on consecutive cycles -> single p_rvalid with 0x5C, 3 cycles after the first handshake.
- Starvation: status=10, p_req and c_req held high continuously -> 8 P grants, then exactly 1 C grant, then the pattern repeats.
- Mode gate: status=00 with both reqs high -> no gnt and mem_wren=0. Switch to 11 with a P read in flight -> P read data is still delivered; only C is granted afterwards.
